// File: rtl/ack_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ack_arb_pkg
//  Description : Shared types, constants and the round-robin pick helper for
//                the ack_arbiter slave-port scheduler.
//                  arb_state_t : access sequencer states
//                  ID_W        : transaction tag width
//                  MAX_NREQ    : upper bound on requester count
//                  rr_pick()   : first set request at/above a pointer
//  Revision    : 1.0  initial release
// ============================================================================
package ack_arb_pkg;

    localparam int ID_W     = 4;
    localparam int MAX_NREQ = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_t;

    // Returns the index of the first set bit of req, searching upward from
    // ptr and wrapping at nreq. The result is only meaningful when req != 0.
    function automatic int rr_pick(input int req, input int ptr, input int nreq);
        int   j;
        int   pick;
        logic found;
        pick  = 0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < MAX_NREQ; k++) begin
            if (k < nreq) begin
                j = ptr + k;
                if (j >= nreq) begin
                    j = j - nreq;
                end
                if (!found && req[j[4:0]]) begin
                    pick  = j;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage : ack_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin selector. Picks the first active
//                request at or above the priority pointer, wrapping at NREQ.
//  Ports       : i_req   [NREQ]   request vector
//                i_ptr   [IDX_W]  priority pointer (highest-priority index)
//                o_gnt   [NREQ]   one-hot grant (zero when no request)
//                o_idx   [IDX_W]  binary index of the granted requester
//                o_valid          at least one request is active
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter
    import ack_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    always_comb begin
        o_idx   = IDX_W'(rr_pick(int'(i_req), int'(i_ptr), NREQ));
        o_valid = |i_req;
        o_gnt   = '0;
        if (o_valid) begin
            o_gnt[o_idx] = 1'b1;
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/ack_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ack_arbiter
//  Description : Shares one fixed-latency slave among NREQ masters. Round-
//                robin grant in IDLE, then GRANT -> WAIT (stage counter) ->
//                ACK, returning a tagged one-hot ack to the granted master.
//  Ports       : clk_i, rst_i (async, active high), ce_i (clock enable)
//                req_i/we_i [NREQ], id_i [4*NREQ]  master request side
//                gnt_o/ack_o [NREQ], cyc_o, we_o     slave/master strobes
//                rid_o/wid_o [4]                     completed read/write tag
//                busy_o                              sequencer not IDLE
//  Config      : `define ACK_ARB_LOCK_EN adds lock_i [NREQ]; a locked master
//                that re-requests on the clock after its ack keeps the grant.
//  Revision    : 1.0  initial release
// ============================================================================
module ack_arbiter
    import ack_arb_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int READ_STAGES  = 3,
    parameter int WRITE_STAGES = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ce_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ-1:0]      we_i,
    input  logic [ID_W*NREQ-1:0] id_i,
`ifdef ACK_ARB_LOCK_EN
    input  logic [NREQ-1:0]      lock_i,
`endif
    output logic [NREQ-1:0]      gnt_o,
    output logic                 cyc_o,
    output logic                 we_o,
    output logic [NREQ-1:0]      ack_o,
    output logic [ID_W-1:0]      rid_o,
    output logic [ID_W-1:0]      wid_o,
    output logic                 busy_o
);

    localparam int c_idx_w  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_max_st = (READ_STAGES > WRITE_STAGES) ? READ_STAGES : WRITE_STAGES;
    localparam int c_cnt_w  = (c_max_st > 0) ? $clog2(c_max_st + 1) : 1;

    localparam logic [c_cnt_w-1:0] c_rd_cnt = c_cnt_w'(READ_STAGES);
    localparam logic [c_cnt_w-1:0] c_wr_cnt = c_cnt_w'(WRITE_STAGES);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    arb_state_t          r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_idx_w-1:0]  r_idx;
    logic [c_idx_w-1:0]  r_ptr;
    logic                r_we;
    logic [ID_W-1:0]     r_tag;
    logic [NREQ-1:0]     r_gnt;
    logic [NREQ-1:0]     r_ack;
    logic [ID_W-1:0]     r_rid;
    logic [ID_W-1:0]     r_wid;
`ifdef ACK_ARB_LOCK_EN
    logic                r_lock;
`endif

    logic [NREQ-1:0]     w_arb_gnt;
    logic [c_idx_w-1:0]  w_arb_idx;
    logic                w_arb_valid;
    logic                w_start;
    logic [c_idx_w-1:0]  w_sel_idx;
    logic [NREQ-1:0]     w_sel_gnt;
    logic                w_req_cur;
    logic [c_idx_w-1:0]  w_next_ptr;
    logic [c_cnt_w-1:0]  w_load;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (c_idx_w)
    ) u_rr (
        .i_req   (req_i),
        .i_ptr   (r_ptr),
        .o_gnt   (w_arb_gnt),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    // Request line of the master currently owning the slave port.
    assign w_req_cur  = req_i[r_idx];
    assign w_next_ptr = (int'(r_idx) == NREQ - 1) ? '0 : r_idx + 1'b1;
    assign w_load     = r_we ? c_wr_cnt : c_rd_cnt;

    // Grant source: normally the round-robin pick; a held lock bypasses
    // arbitration and re-serves the previous owner if it asks again.
    always_comb begin
        w_start   = w_arb_valid;
        w_sel_idx = w_arb_idx;
        w_sel_gnt = w_arb_gnt;
`ifdef ACK_ARB_LOCK_EN
        if (r_lock) begin
            w_start          = w_req_cur;
            w_sel_idx        = r_idx;
            w_sel_gnt        = '0;
            w_sel_gnt[r_idx] = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_we    <= 1'b0;
            r_tag   <= '0;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_rid   <= '0;
            r_wid   <= '0;
`ifdef ACK_ARB_LOCK_EN
            r_lock  <= 1'b0;
`endif
        end else if (ce_i) begin
            case (r_state)
                IDLE: begin
`ifdef ACK_ARB_LOCK_EN
                    r_lock <= 1'b0;
                    // Locked owner did not come back: hand priority onward.
                    if (r_lock && !w_req_cur) begin
                        r_ptr <= w_next_ptr;
                    end
`endif
                    if (w_start) begin
                        r_idx   <= w_sel_idx;
                        r_we    <= we_i[w_sel_idx];
                        r_tag   <= id_i[int'(w_sel_idx)*ID_W +: ID_W];
                        r_gnt   <= w_sel_gnt;
                        r_state <= GRANT;
                    end
                end

                GRANT: begin
                    if (!w_req_cur) begin
                        // Aborted before the slave answered: no ack.
                        r_gnt   <= '0;
                        r_we    <= 1'b0;
                        r_ptr   <= w_next_ptr;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= w_load;
                        if (w_load == '0) begin
                            r_ack   <= r_gnt;
                            if (r_we) r_wid <= r_tag;
                            else      r_rid <= r_tag;
                            r_state <= ACK;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    if (!w_req_cur) begin
                        r_gnt   <= '0;
                        r_we    <= 1'b0;
                        r_ptr   <= w_next_ptr;
                        r_state <= IDLE;
                    end else if (r_cnt == c_cnt_one) begin
                        // Counter is left at 1; it is reloaded on next GRANT.
                        r_ack   <= r_gnt;
                        if (r_we) r_wid <= r_tag;
                        else      r_rid <= r_tag;
                        r_state <= ACK;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                ACK: begin
                    // Ack is held until the master withdraws its request.
                    if (!w_req_cur) begin
                        r_ack   <= '0;
                        r_gnt   <= '0;
                        r_we    <= 1'b0;
                        r_state <= IDLE;
`ifdef ACK_ARB_LOCK_EN
                        if (lock_i[r_idx]) r_lock <= 1'b1;
                        else               r_ptr  <= w_next_ptr;
`else
                        r_ptr   <= w_next_ptr;
`endif
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt_o  = r_gnt;
    assign ack_o  = r_ack;
    assign we_o   = r_we;
    assign rid_o  = r_rid;
    assign wid_o  = r_wid;
    assign busy_o = (r_state != IDLE);
    assign cyc_o  = (r_state != IDLE);

endmodule : ack_arbiter
`default_nettype wire

// File: tb/tb_ack_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ack_arbiter
//  Description : Self-checking bench for ack_arbiter. A transaction-level
//                model (owner, latched we/tag, enabled clocks since grant,
//                round-robin pointer) predicts every output each cycle.
//                Directed scenarios first, then randomized masters.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ack_arbiter;

    localparam int NREQ         = 4;
    localparam int READ_STAGES  = 3;
    localparam int WRITE_STAGES = 0;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                ce_i;
    logic [NREQ-1:0]     req_i;
    logic [NREQ-1:0]     we_i;
    logic [4*NREQ-1:0]   id_i;
`ifdef ACK_ARB_LOCK_EN
    logic [NREQ-1:0]     lock_i = '0;
`endif
    logic [NREQ-1:0]     gnt_o;
    logic                cyc_o;
    logic                we_o;
    logic [NREQ-1:0]     ack_o;
    logic [3:0]          rid_o;
    logic [3:0]          wid_o;
    logic                busy_o;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit   m_busy;
    int   m_owner;
    bit   m_we;
    int   m_tag;
    int   m_elapsed;
    int   m_ptr;

    int   hold [NREQ];

    ack_arbiter #(
        .NREQ         (NREQ),
        .READ_STAGES  (READ_STAGES),
        .WRITE_STAGES (WRITE_STAGES)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .ce_i   (ce_i),
        .req_i  (req_i),
        .we_i   (we_i),
        .id_i   (id_i),
`ifdef ACK_ARB_LOCK_EN
        .lock_i (lock_i),
`endif
        .gnt_o  (gnt_o),
        .cyc_o  (cyc_o),
        .we_o   (we_o),
        .ack_o  (ack_o),
        .rid_o  (rid_o),
        .wid_o  (wid_o),
        .busy_o (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int lat_of(input bit we);
        return 1 + (we ? WRITE_STAGES : READ_STAGES);
    endfunction

    function automatic void model_reset();
        m_busy    = 1'b0;
        m_owner   = 0;
        m_we      = 1'b0;
        m_tag     = 0;
        m_elapsed = 0;
        m_ptr     = 0;
    endfunction

    // Advances the model by one clock edge using the inputs seen at that edge.
    function automatic void model_edge();
        int j;
        if (rst_i) begin
            model_reset();
            return;
        end
        if (!ce_i) return;
        if (!m_busy) begin
            for (int k = 0; k < NREQ; k++) begin
                j = (m_ptr + k) % NREQ;
                if (!m_busy && req_i[j]) begin
                    m_busy    = 1'b1;
                    m_owner   = j;
                    m_we      = we_i[j];
                    m_tag     = int'(id_i[4*j +: 4]);
                    m_elapsed = 0;
                end
            end
        end else if (!req_i[m_owner]) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % NREQ;
        end else if (m_elapsed < lat_of(m_we)) begin
            m_elapsed++;
        end
    endfunction

    task automatic compare_all();
        logic [NREQ-1:0] eg;
        bit acked;
        eg    = m_busy ? (NREQ'(1) << m_owner) : '0;
        acked = m_busy && (m_elapsed == lat_of(m_we));
        check("gnt",  32'(gnt_o),  32'(eg));
        check("ack",  32'(ack_o),  acked ? 32'(eg) : 32'd0);
        check("cyc",  32'(cyc_o),  32'(m_busy));
        check("busy", 32'(busy_o), 32'(m_busy));
        if (m_busy) check("we", 32'(we_o), 32'(m_we));
        if (acked) begin
            if (m_we) check("wid", 32'(wid_o), 32'(m_tag));
            else      check("rid", 32'(rid_o), 32'(m_tag));
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
        compare_all();
    endtask

    task automatic do_reset();
        req_i = '0;
        we_i  = '0;
        id_i  = '0;
        ce_i  = 1'b1;
        rst_i = 1'b1;
        model_reset();
        tick();
        tick();
        rst_i = 1'b0;
        tick();
    endtask

    // Issues one access from master n; lat counts clocks until ack appears.
    // ce_i is held low for ce_gap clocks starting once the access is in WAIT.
    task automatic run_access(input int n, input bit we, input logic [3:0] id,
                              input int ce_gap, output int lat);
        req_i[n]        = 1'b1;
        we_i[n]         = we;
        id_i[4*n +: 4]  = id;
        lat = 0;
        while (!ack_o[n] && lat < 40) begin
            ce_i = !(ce_gap > 0 && lat >= 2 && lat < 2 + ce_gap);
            tick();
            lat++;
        end
        ce_i = 1'b1;
    endtask

    task automatic wait_ack(input int n);
        int c = 0;
        while (!ack_o[n] && c < 40) begin
            tick();
            c++;
        end
        check($sformatf("ack_seen_m%0d", n), 32'(ack_o[n]), 32'd1);
    endtask

    task automatic drive_random();
        ce_i = ($urandom_range(0, 7) != 0);
        for (int n = 0; n < NREQ; n++) begin
            if (!req_i[n]) begin
                if ($urandom_range(0, 3) == 0) begin
                    req_i[n]       = 1'b1;
                    we_i[n]        = 1'($urandom);
                    id_i[4*n +: 4] = 4'($urandom);
                    hold[n]        = $urandom_range(0, 2);
                end
            end else if (ack_o[n]) begin
                if (hold[n] == 0) req_i[n] = 1'b0;
                else              hold[n]--;
            end else if ($urandom_range(0, 29) == 0) begin
                req_i[n] = 1'b0;
            end else if (gnt_o[n] && $urandom_range(0, 3) == 0) begin
                // Late changes must not affect the access in flight.
                we_i[n]        = ~we_i[n];
                id_i[4*n +: 4] = 4'($urandom);
            end
        end
    endtask

    initial begin
        int lat;
        int c;
        rst_i = 1'b1;
        ce_i  = 1'b1;
        req_i = '0;
        we_i  = '0;
        id_i  = '0;
        model_reset();
        for (int n = 0; n < NREQ; n++) hold[n] = 0;
        @(negedge clk_i);
        #1;
        check("rst_gnt",  32'(gnt_o),  32'd0);
        check("rst_ack",  32'(ack_o),  32'd0);
        check("rst_cyc",  32'(cyc_o),  32'd0);
        check("rst_we",   32'(we_o),   32'd0);
        check("rst_rid",  32'(rid_o),  32'd0);
        check("rst_wid",  32'(wid_o),  32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        do_reset();

        // Master 0 read, tag 5
        run_access(0, 1'b0, 4'h5, 0, lat);
        check("m0_rd_lat", 32'(lat), 32'(2 + READ_STAGES));
        check("m0_rid",    32'(rid_o), 32'h5);
        check("m0_ack",    32'(ack_o), 32'b0001);
        tick();
        check("m0_hold1",  32'(ack_o), 32'b0001);
        tick();
        check("m0_hold2",  32'(ack_o), 32'b0001);
        req_i[0] = 1'b0;
        tick();
        check("m0_idle",   32'(busy_o), 32'd0);
        check("m0_noack",  32'(ack_o),  32'd0);

        // Masters 1 and 2 together from pointer 0, then 1 again
        do_reset();
        id_i[4 +: 4] = 4'h1;
        id_i[8 +: 4] = 4'h2;
        req_i = 4'b0110;
        tick();
        check("rr_first", 32'(gnt_o), 32'b0010);
        wait_ack(1);
        req_i[1] = 1'b0;
        tick();
        req_i[1] = 1'b1;
        tick();
        check("rr_second", 32'(gnt_o), 32'b0100);
        wait_ack(2);
        req_i[2] = 1'b0;
        tick();
        tick();
        check("rr_third", 32'(gnt_o), 32'b0010);
        wait_ack(1);
        req_i[1] = 1'b0;
        tick();

        // Master 3 write, tag A, zero write stages
        run_access(3, 1'b1, 4'hA, 0, lat);
        check("m3_wr_lat", 32'(lat),   32'(2 + WRITE_STAGES));
        check("m3_wid",    32'(wid_o), 32'hA);
        check("m3_we",     32'(we_o),  32'd1);
        req_i[3] = 1'b0;
        tick();

        // Clock-enable gap of 5 inside WAIT
        run_access(0, 1'b0, 4'h3, 5, lat);
        check("ce_gap_lat", 32'(lat), 32'(2 + READ_STAGES + 5));
        req_i[0] = 1'b0;
        tick();

        // Abort during WAIT
        req_i[2] = 1'b1;
        we_i[2]  = 1'b0;
        tick();
        tick();
        check("abort_busy_pre", 32'(busy_o), 32'd1);
        req_i[2] = 1'b0;
        tick();
        check("abort_idle",  32'(busy_o), 32'd0);
        check("abort_noack", 32'(ack_o),  32'd0);
        tick();

        // Asynchronous reset in the middle of WAIT
        req_i[1] = 1'b1;
        tick();
        tick();
        tick();
        #2;
        rst_i = 1'b1;
        #1;
        model_reset();
        check("arst_gnt",  32'(gnt_o),  32'd0);
        check("arst_ack",  32'(ack_o),  32'd0);
        check("arst_cyc",  32'(cyc_o),  32'd0);
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_rid",  32'(rid_o),  32'd0);
        @(negedge clk_i);
        req_i = '0;
        rst_i = 1'b0;
        tick();

        // Randomized masters
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            tick();
        end

        // Drain
        req_i = '0;
        ce_i  = 1'b1;
        c = 0;
        while (busy_o && c < 20) begin
            tick();
            c++;
        end
        check("drain_idle", 32'(busy_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ack_arbiter
`default_nettype wire
